lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store controller of the pipelined CPU.
- Accepts one load or store per instruction from the EX/MEM register and drives a valid/ready data-memory bus.
- For loads, returns the raw word shifted to bit 0 plus the latched func3. The downstream load-extension stage then sign- or zero-extends that data.
- Stalls the pipeline while a bus transaction is outstanding. Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ+WAIT before the access is aborted with bus_err.
- CNT_W, 5: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- mem_rd, input, 1: load in the MEM stage.
- mem_wr, input, 1: store in the MEM stage. mem_rd and mem_wr are never both 1.
- func3, input, 3: instr[14:12] of the access.
- addr, input, 32: effective byte address.
- wdata, input, 32: store data (rs2).
- bus_valid, output, 1: request valid.
- bus_ready, input, 1: request accepted.
- bus_we, output, 1: 1 = write.
- bus_addr, output, 32: word address, {addr[31:2], 2'b00}.
- bus_wdata, output, 32: lane-replicated store data.
- bus_be, output, 4: byte enables.
- bus_rvalid, input, 1: read data valid.
- bus_rdata, input, 32: read data.
- stall, output, 1: freeze the pipeline.
- load_valid, output, 1: load_data is valid for one cycle.
- load_data, output, 32: bus_rdata >> (8*addr[1:0]), not extended.
- func3_out, output, 3: func3 latched with the access, for the extension stage.
- misalign, output, 1: one-cycle misaligned-access flag.
- bus_err, output, 1: one-cycle timeout flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States:
  - IDLE: no access in flight.
  - REQ: bus_valid=1, waiting for bus_ready.
  - WAIT: load accepted, waiting for bus_rvalid.
  - DONE: one cycle, result presented.
- Alignment:
  - func3 001/101 (halfword) is misaligned if addr[0]=1.
  - func3 010 (word) is misaligned if addr[1:0]≠0.
  - All other func3 values are always aligned.
- IDLE with (mem_rd|mem_wr) and aligned:
  - stall=1 combinationally in the same cycle.
  - Latch addr, func3, wdata, and the we flag.
  - Next state REQ.
- IDLE with a misaligned access:
  - misalign=1 for one cycle, registered, appearing the next cycle.
  - No bus request; stall stays 0; next state IDLE.
- Byte enables:
  - SB (000): 4'b0001 << addr[1:0].
  - SH (001): 4'b0011 << {addr[1],1'b0}.
  - SW and others: 4'b1111.
  - Loads drive bus_be=4'b1111.
- Store data lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - Otherwise: wdata.
- REQ:
  - bus_valid, bus_we, bus_addr, bus_be, bus_wdata are driven from latched values and held stable until bus_ready=1.
  - On bus_ready with a store: next state DONE.
  - On bus_ready with a load: next state WAIT. If bus_rvalid=1 in the same cycle, next state DONE and capture data directly.
- WAIT: bus_valid=0. On bus_rvalid, capture load_data = bus_rdata >> (8*latched addr[1:0]). Next state DONE.
- DONE:
  - stall=0.
  - load_valid=1 for loads only; func3_out holds the latched func3.
  - Next state IDLE unconditionally. The pipeline advances this cycle, so the access is not re-accepted.
- Outputs are held until the next load capture:
  - load_data holds its last captured value.
  - func3_out is updated at acceptance.
- stall = (IDLE & accepted access) | REQ | WAIT.
- Timeout:
  - The counter is cleared on entry to REQ and increments each cycle in REQ or WAIT.
  - At TIMEOUT_CYCLES-1 without completion: bus_err=1 for one cycle (in DONE), load_data=0, load_valid=0, next state DONE.
- bus_rvalid outside WAIT (or REQ with bus_ready) is ignored.
- Reset mid-operation: returns to IDLE at that edge and bus_valid drops. A late bus_rvalid is ignored.

Test Plan:
- LW addr=0x100, bus_ready after 2 cycles, bus_rvalid=1 with rdata=0xDEADBEEF 1 cycle later -> stall high 4 cycles; load_valid=1 with load_data=0xDEADBEEF, func3_out=010.
- LB addr=0x103, rdata=0x80AABBCC -> load_data=0x00000080, func3_out=000; bus_addr=0x100, bus_be=1111.
- SH addr=0x202, wdata=0x1234ABCD, ready immediately -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1; stall high 2 cycles; load_valid stays 0.
- LW addr=0x101 -> no bus_valid; misalign=1 for exactly one cycle; stall=0.
- Load with bus_ready never asserted -> bus_err pulse after TIMEOUT_CYCLES=16 cycles; stall deasserts in DONE; load_data=0.
- rst asserted in WAIT, then bus_rvalid=1 with rdata=0x55 -> IDLE; no load_valid; outputs 0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: turns one EX/MEM load or store into a
// valid/ready data-memory transaction, stalling the pipeline until it retires.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [2:0]  func3_out,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [2:0]         func3_q;
    logic [31:0]        load_data_q;
    logic               load_valid_q;
    logic               bus_err_q;
    logic               misalign_q;

    logic               access;
    logic               misal;
    logic               accept;
    logic               timeout_hit;
    logic               capture;
    logic               abort;
    logic [3:0]         be_new;
    logic [31:0]        lanes_new;

    assign access      = mem_rd | mem_wr;
    assign accept      = (state_q == IDLE) & access & ~misal;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        misal = 1'b0;
        case (func3)
            3'b001, 3'b101: misal = addr[0];
            3'b010:         misal = |addr[1:0];
            default:        misal = 1'b0;
        endcase
    end

    // Byte enables and replicated lanes are resolved at acceptance so REQ only replays registers.
    always_comb begin
        be_new    = 4'b1111;
        lanes_new = wdata;
        case (func3)
            3'b000: begin
                be_new    = 4'b0001 << addr[1:0];
                lanes_new = {4{wdata[7:0]}};
            end
            3'b001: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                lanes_new = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (mem_rd)
            be_new = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Completion always wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (bus_ready) begin
                    if (we_q || bus_rvalid) state_d = DONE;
                    else                    state_d = WAIT;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WAIT: if (bus_rvalid || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_valid = (state_q == REQ);
        stall     = accept | (state_q == REQ) | (state_q == WAIT);
        bus_we    = bus_valid & we_q;
        bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be    = bus_valid ? be_q : 4'd0;
        bus_wdata = bus_valid ? wdata_q : 32'd0;
        capture   = bus_rvalid & ((state_q == WAIT) | ((state_q == REQ) & bus_ready & ~we_q));
        abort     = timeout_hit & (((state_q == REQ) & ~bus_ready) |
                                   ((state_q == WAIT) & ~bus_rvalid));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if (state_q == REQ || state_q == WAIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            func3_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                we_q    <= mem_wr;
                be_q    <= be_new;
                wdata_q <= lanes_new;
                func3_q <= func3;
            end
            if (capture)
                load_data_q <= bus_rdata >> {addr_q[1:0], 3'b000};
            else if (abort)
                load_data_q <= '0;
            load_valid_q <= capture;
            bus_err_q    <= abort;
            misalign_q   <= (state_q == IDLE) & access & misal;
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign func3_out  = func3_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a transaction-level model sets the expected
// outputs each cycle, a negedge process compares, literal checks pin the model.
module tb_lsu_mem_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] load_data;
    logic [2:0]  func3_out;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .func3(func3),
        .addr(addr), .wdata(wdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .stall(stall),
        .load_valid(load_valid), .load_data(load_data), .func3_out(func3_out),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    logic        e_valid, e_we, e_stall, e_lv, e_mis, e_err, e_bus_chk, e_wd_chk;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_be;
    logic [2:0]  e_f3;

    logic [31:0] m_ld = 32'd0;
    logic [2:0]  m_f3 = 3'd0;

    int          stall_cyc, lv_cnt, err_cnt, mis_cnt;
    logic [31:0] last_ld, seen_wd, seen_addr;
    logic [2:0]  last_f3;
    logic [3:0]  seen_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_valid",  32'(bus_valid),  32'(e_valid));
            chk("stall",      32'(stall),      32'(e_stall));
            chk("load_valid", 32'(load_valid), 32'(e_lv));
            chk("load_data",  load_data,       e_ld);
            chk("func3_out",  32'(func3_out),  32'(e_f3));
            chk("misalign",   32'(misalign),   32'(e_mis));
            chk("bus_err",    32'(bus_err),    32'(e_err));
            if (e_bus_chk) begin
                chk("bus_we",   32'(bus_we), 32'(e_we));
                chk("bus_addr", bus_addr,    e_addr);
                chk("bus_be",   32'(bus_be), 32'(e_be));
            end
            if (e_wd_chk)
                chk("bus_wdata", bus_wdata, e_wdata);
            if (stall) stall_cyc++;
            if (load_valid) begin
                lv_cnt++;
                last_ld = load_data;
                last_f3 = func3_out;
            end
            if (bus_err)  err_cnt++;
            if (misalign) mis_cnt++;
            if (bus_valid) begin
                seen_be   = bus_be;
                seen_wd   = bus_wdata;
                seen_addr = bus_addr;
            end
        end
    end

    function automatic bit f_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        if (f3 == 3'b010) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] f_be(input bit rd, input logic [2:0] f3, input logic [31:0] a);
        if (rd) return 4'b1111;
        if (f3 == 3'b000) return 4'(1 << int'(a[1:0]));
        if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_lanes(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'b000) return {4{w[7:0]}};
        if (f3 == 3'b001) return {2{w[15:0]}};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_valid = 0; e_we = 0; e_stall = 0; e_lv = 0; e_mis = 0; e_err = 0;
        e_bus_chk = 0; e_wd_chk = 0;
        e_addr = 0; e_wdata = 0; e_be = 0; e_ld = m_ld; e_f3 = m_f3;
    endtask

    task automatic clr_obs();
        stall_cyc = 0; lv_cnt = 0; err_cnt = 0; mis_cnt = 0;
        last_ld = 0; last_f3 = 0; seen_be = 0; seen_wd = 0; seen_addr = 0;
    endtask

    // rdy: REQ cycle index of bus_ready (-1 = never); rvd: cycles after ready for rvalid.
    task automatic run(input bit rd, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input int rdy, input int rvd,
                       input logic [31:0] rdata);
        int n;
        bit inreq, done, ok;
        step();
        mem_rd = rd; mem_wr = !rd; func3 = f3; addr = a; wdata = w;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = rdata;
        clr_obs();
        idle_exp();
        e_stall = !f_mis(f3, a);
        if (f_mis(f3, a)) begin
            step();
            mem_rd = 0; mem_wr = 0;
            idle_exp(); e_mis = 1;
            step();
            idle_exp();
            return;
        end
        m_f3 = f3;
        n = 0; inreq = 1; done = 0; ok = 0;
        while (!done) begin
            step();
            bus_ready  = inreq && (n == rdy);
            bus_rvalid = rd && ((inreq && n == rdy && rvd == 0) || (!inreq && n == rdy + rvd));
            idle_exp();
            e_stall = 1;
            e_valid = inreq;
            if (inreq) begin
                e_bus_chk = 1;
                e_we      = !rd;
                e_addr    = {a[31:2], 2'b00};
                e_be      = f_be(rd, f3, a);
                e_wd_chk  = !rd;
                e_wdata   = f_lanes(f3, w);
            end
            if (inreq && bus_ready) begin
                if (!rd || bus_rvalid) begin done = 1; ok = 1; end
                else inreq = 0;
            end else if (!inreq && bus_rvalid) begin
                done = 1; ok = 1;
            end
            if (!done && n == TO - 1) done = 1;
            n++;
        end
        step();
        bus_ready = 0; bus_rvalid = 0;
        if (ok && rd) m_ld = rdata >> (8 * int'(a[1:0]));
        else if (!ok) m_ld = 32'd0;
        idle_exp();
        e_lv  = ok && rd;
        e_err = !ok;
        step();
        mem_rd = 0; mem_wr = 0;
        bus_rvalid = 1;
        bus_rdata  = 32'hFFFF_FFFF;
        idle_exp();
        step();
        bus_rvalid = 0;
        idle_exp();
    endtask

    initial begin
        rst = 1; mem_rd = 0; mem_wr = 0; func3 = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        clr_obs();
        step(); step();
        idle_exp(); e_bus_chk = 1; e_wd_chk = 1;
        chk_en = 1;
        step();
        rst = 0;
        idle_exp();

        run(1, 3'b010, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(stall_cyc), 32'd4);
        chk("lw_load_data",    last_ld,        32'hDEADBEEF);
        chk("lw_func3_out",    32'(last_f3),   32'd2);

        run(1, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80AABBCC);
        chk("lb_load_data", last_ld,        32'h00000080);
        chk("lb_func3_out", 32'(last_f3),   32'd0);
        chk("lb_bus_addr",  seen_addr,      32'h100);
        chk("lb_bus_be",    32'(seen_be),   32'hF);

        run(0, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0);
        chk("sh_bus_be",       32'(seen_be),   32'hC);
        chk("sh_bus_wdata",    seen_wd,        32'hABCDABCD);
        chk("sh_stall_cycles", 32'(stall_cyc), 32'd2);
        chk("sh_load_valid",   32'(lv_cnt),    32'd0);

        run(1, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        chk("misal_pulses", 32'(mis_cnt),   32'd1);
        chk("misal_stall",  32'(stall_cyc), 32'd0);

        run(1, 3'b010, 32'h104, 32'h0, -1, 0, 32'h0);
        chk("to_err_pulses",   32'(err_cnt),   32'd1);
        chk("to_stall_cycles", 32'(stall_cyc), 32'd17);
        chk("to_load_valid",   32'(lv_cnt),    32'd0);
        chk("to_load_data",    load_data,      32'd0);

        run(0, 3'b000, 32'h201, 32'h7777775A, 2, 0, 32'h0);
        chk("sb_bus_be",    32'(seen_be), 32'h2);
        chk("sb_bus_wdata", seen_wd,      32'h5A5A5A5A);

        run(1, 3'b001, 32'h102, 32'h0, 0, 2, 32'h12348000);
        chk("lh_load_data", last_ld, 32'h00001234);

        run(1, 3'b100, 32'h101, 32'h0, 3, 1, 32'h11223344);
        chk("lbu_load_data", last_ld, 32'h00112233);

        run(0, 3'b010, 32'h404, 32'hCAFEF00D, 1, 0, 32'h0);
        run(0, 3'b001, 32'h203, 32'h0, 0, 0, 32'h0);
        run(1, 3'b010, 32'h300, 32'h0, 3, 100, 32'h0);
        chk("wait_to_err", 32'(err_cnt), 32'd1);

        run(1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0BADF00D);

        // Reset while waiting for read data, then a late rvalid.
        step();
        clr_obs();
        mem_rd = 1; func3 = 3'b010; addr = 32'h100;
        idle_exp(); e_stall = 1;
        m_f3 = 3'b010;
        step();
        bus_ready = 1;
        idle_exp(); e_stall = 1; e_valid = 1; e_bus_chk = 1;
        e_we = 0; e_addr = 32'h100; e_be = 4'hF;
        step();
        bus_ready = 0; rst = 1;
        idle_exp(); e_stall = 1;
        step();
        rst = 0; mem_rd = 0; bus_rvalid = 1; bus_rdata = 32'h55;
        m_ld = 0; m_f3 = 0;
        idle_exp(); e_bus_chk = 1; e_wd_chk = 1;
        step();
        bus_rvalid = 0;
        idle_exp(); e_bus_chk = 1; e_wd_chk = 1;
        step();
        chk("rst_load_valid", 32'(lv_cnt), 32'd0);
        chk("rst_load_data",  load_data,   32'd0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
